// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_resolution_unit_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_predict;
  } slot_t;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/branch_resolution_unit_next_pc_calc.sv
// Combinational actual-next-PC of the EX instruction; JALR > JAL > branch priority.
module next_pc_calc
  import branch_resolution_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  input  logic        is_branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        bcond_i,
  output logic [31:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i + PC_INC;
    if (is_jalr_i) begin
      next_pc_o = (rs1_i + imm_i) & JALR_MASK;
    end else if (is_jal_i || (is_branch_i && bcond_i)) begin
      next_pc_o = pc_i + imm_i;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Tracks ID/EX slots, checks EX prediction against the actual next PC and flushes.
// Optional counters enabled by macro BRU_STATS_EN.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc_predict,
  input  logic        stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        ex_bcond,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1_data,
  output logic        prediction_sucess,
  output logic [31:0] pc_correct,
  output logic        flush_if_id,
  output logic        flush_id_ex
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_ctrl_count,
  output logic [31:0] stat_mispredict_count
`endif
);

  slot_t       id_q, id_d;
  slot_t       ex_q, ex_d;
  logic [31:0] actual_next;
  logic        mispredict;

  next_pc_calc u_next_pc_calc (
    .pc_i        (ex_q.pc),
    .imm_i       (ex_imm),
    .rs1_i       (ex_rs1_data),
    .is_branch_i (ex_is_branch),
    .is_jal_i    (ex_is_jal),
    .is_jalr_i   (ex_is_jalr),
    .bcond_i     (ex_bcond),
    .next_pc_o   (actual_next)
  );

  assign mispredict        = ex_q.valid && (actual_next != ex_q.pc_predict);
  assign prediction_sucess = !mispredict;
  assign pc_correct        = ex_q.valid ? actual_next : 32'd0;
  assign flush_if_id       = mispredict;
  assign flush_id_ex       = mispredict;

  // Mispredict kills both slots and overrides stall; stall holds ID and bubbles EX.
  always_comb begin
    id_d = id_q;
    ex_d = ex_q;
    if (mispredict) begin
      id_d.valid = 1'b0;
      ex_d.valid = 1'b0;
    end else if (stall) begin
      ex_d.valid = 1'b0;
    end else begin
      id_d = '{valid: if_valid, pc: if_pc, pc_predict: if_pc_predict};
      ex_d = id_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q <= '0;
      ex_q <= '0;
    end else begin
      id_q <= id_d;
      ex_q <= ex_d;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  assign ctrl_cnt_d = (ex_q.valid && (ex_is_branch || ex_is_jal || ex_is_jalr))
                      ? ctrl_cnt_q + 32'd1 : ctrl_cnt_q;
  assign mis_cnt_d  = mispredict ? mis_cnt_q + 32'd1 : mis_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_cnt_q <= '0;
      mis_cnt_q  <= '0;
    end else begin
      ctrl_cnt_q <= ctrl_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign stat_ctrl_count       = ctrl_cnt_q;
  assign stat_mispredict_count = mis_cnt_q;
`endif

endmodule
